// File: rtl/mm_sched.sv
// Job sequencer for an NxN systolic MAC array: clears the array, streams K operand
// columns/rows from the buffers, skews them onto the array edges and flags results valid.
module mm_sched #(
  parameter int N  = 4,
  parameter int DW = 4,
  parameter int KW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  output logic            res_valid,
  output logic            pe_rst,
  output logic            a_rd_en,
  output logic            b_rd_en,
  output logic [KW-1:0]   rd_addr,
  input  logic [N*DW-1:0] a_in,
  input  logic [N*DW-1:0] b_in,
  output logic [N*DW-1:0] left_bus,
  output logic [N*DW-1:0] up_bus
);

  localparam int CW = $clog2(2 * N);
  // Drain covers the read latency plus the skew and propagation to the far corner PE.
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          res_valid_q, res_valid_d;
  logic          busy_q, done_q, pe_rst_q, rd_en_q, rd_vld_q;
  logic          abort_acc;

  assign abort_acc = abort && (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CLEAR;
          k_d         = k_len;
          addr_d      = '0;
          res_valid_d = 1'b0;
        end
      end
      S_CLEAR: begin
        addr_d  = '0;
        state_d = (k_q == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        if (addr_q == k_q - KW'(1)) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LAST;
        end else begin
          addr_d = addr_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d == S_DONE) begin
      res_valid_d = 1'b1;
    end
    if (abort_acc) begin
      state_d     = S_IDLE;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pe_rst_q    <= 1'b1;
      rd_en_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      pe_rst_q    <= (state_d == S_CLEAR);
      rd_en_q     <= (state_d == S_FEED);
      rd_vld_q    <= abort_acc ? 1'b0 : rd_en_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign pe_rst    = pe_rst_q;
  assign a_rd_en   = rd_en_q;
  assign b_rd_en   = rd_en_q;
  assign rd_addr   = addr_q;

  logic [DW-1:0] a_gate [N];
  logic [DW-1:0] b_gate [N];

  // Lane i is delayed i cycles; data outside the operand window is forced to zero.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign a_gate[gi] = rd_vld_q ? a_in[gi*DW +: DW] : '0;
    assign b_gate[gi] = rd_vld_q ? b_in[gi*DW +: DW] : '0;

    if (gi == 0) begin : g_direct
      assign left_bus[0 +: DW] = a_gate[0];
      assign up_bus[0 +: DW]   = b_gate[0];
    end else begin : g_skew
      logic [DW-1:0] a_sk_q [gi];
      logic [DW-1:0] b_sk_q [gi];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < gi; d++) begin
            a_sk_q[d] <= '0;
            b_sk_q[d] <= '0;
          end
        end else if (abort_acc) begin
          for (int d = 0; d < gi; d++) begin
            a_sk_q[d] <= '0;
            b_sk_q[d] <= '0;
          end
        end else begin
          a_sk_q[0] <= a_gate[gi];
          b_sk_q[0] <= b_gate[gi];
          for (int d = 1; d < gi; d++) begin
            a_sk_q[d] <= a_sk_q[d-1];
            b_sk_q[d] <= b_sk_q[d-1];
          end
        end
      end

      assign left_bus[gi*DW +: DW] = a_sk_q[gi-1];
      assign up_bus[gi*DW +: DW]   = b_sk_q[gi-1];
    end
  end

endmodule

// File: tb/tb_mm_sched.sv
// Randomized bench for mm_sched: a cycle-schedule reference model plus a behavioural
// systolic PE array fed from the DUT edges, checked against the matrix product.
module tb_mm_sched;
  localparam int N   = 4;
  localparam int DW  = 4;
  localparam int KW  = 8;
  localparam int W   = N * DW;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic          busy, done, res_valid, pe_rst, a_rd_en, b_rd_en;
  logic [KW-1:0] rd_addr;
  logic [W-1:0]  left_bus, up_bus;

  always #5 clk = ~clk;

  mm_sched #(.N(N), .DW(DW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .k_len(k_len),
    .busy(busy), .done(done), .res_valid(res_valid), .pe_rst(pe_rst),
    .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .rd_addr(rd_addr),
    .a_in(a_in), .b_in(b_in), .left_bus(left_bus), .up_bus(up_bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference job state: start cycle, K, done cycle, abort cycle (BIG if none).
  bit in_rst = 1'b1;
  int rel_cyc = -100;
  bit job_v = 1'b0;
  bit ever_job = 1'b0;
  int js, jk, jd;
  int jend = BIG;
  int am [N][256];
  int bm [256][N];
  int sa [N][256];
  int sb [256][N];
  bit pend_en = 1'b0;
  int pend_addr = 0;

  // Behavioural systolic array driven by the DUT's edge buses.
  int acc [N][N];
  int ah [N][N];
  int bh [N][N];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pe_a(int i, int j);
    return (j == 0) ? int'(left_bus[i*DW +: DW]) : ah[i][j-1];
  endfunction

  function automatic int pe_b(int i, int j);
    return (i == 0) ? int'(up_bus[j*DW +: DW]) : bh[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (pe_rst) begin
          acc[i][j] <= 0;
          ah[i][j]  <= 0;
          bh[i][j]  <= 0;
        end else begin
          acc[i][j] <= acc[i][j] + pe_a(i, j) * pe_b(i, j);
          ah[i][j]  <= pe_a(i, j);
          bh[i][j]  <= pe_b(i, j);
        end
      end
    end
  end

  task automatic check_cycle();
    int t = cyc;
    logic e_busy = 1'b0, e_done = 1'b0, e_rv = 1'b0, e_pe = 1'b0, e_rd = 1'b0;
    int e_addr = 0;
    logic [W-1:0] e_left = '0, e_up = '0;
    if (in_rst) begin
      e_pe = 1'b1;
    end else begin
      e_pe = (t == rel_cyc);
      if (job_v) begin
        e_busy = (t >= js + 1) && (t <= jd) && (t <= jend);
        e_done = (t == jd) && (t <= jend);
        e_rv   = (t >= jd) && (t <= jend);
        e_pe   = e_pe || (t == js + 1);
        e_rd   = (t >= js + 2) && (t <= js + jk + 1) && (t <= jend);
        e_addr = t - js - 2;
        for (int i = 0; i < N; i++) begin
          int k = t - js - 3 - i;
          if (t <= jend && k >= 0 && k < jk) begin
            e_left[i*DW +: DW] = DW'(am[i][k]);
            e_up[i*DW +: DW]   = DW'(bm[k][i]);
          end
        end
      end
    end
    check_val("busy", 32'(busy), 32'(e_busy));
    check_val("done", 32'(done), 32'(e_done));
    check_val("res_valid", 32'(res_valid), 32'(e_rv));
    check_val("pe_rst", 32'(pe_rst), 32'(e_pe));
    check_val("a_rd_en", 32'(a_rd_en), 32'(e_rd));
    check_val("b_rd_en", 32'(b_rd_en), 32'(e_rd));
    if (e_rd) check_val("rd_addr", 32'(rd_addr), 32'(e_addr));
    else if (!ever_job) check_val("rd_addr_idle", 32'(rd_addr), 32'd0);
    check_val("left_bus", 32'(left_bus), 32'(e_left));
    check_val("up_bus", 32'(up_bus), 32'(e_up));
    if (e_done) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          int s = 0;
          for (int k = 0; k < jk; k++) s += am[i][k] * bm[k][j];
          check_val($sformatf("sum[%0d][%0d]", i, j), 32'(acc[i][j]), 32'(s));
        end
      end
    end
  endtask

  task automatic update_model();
    int t = cyc;
    bit idle;
    if (in_rst) return;
    idle = !job_v || (t > jd) || (t > jend);
    if (start && idle) begin
      js = t;
      jk = int'(k_len);
      jd = (jk == 0) ? t + 2 : t + jk + 2 * N + 1;
      jend = BIG;
      job_v = 1'b1;
      ever_job = 1'b1;
      am = sa;
      bm = sb;
    end else if (abort && !idle) begin
      jend = t;
    end
  endtask

  always @(negedge clk) begin
    check_cycle();
    update_model();
    pend_en   = a_rd_en;
    pend_addr = int'(rd_addr);
  end

  task automatic tick(input bit st = 1'b0, input bit ab = 1'b0, input int kl = 0,
                      input bit rel = 1'b0);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      a_in[i*DW +: DW] = pend_en ? DW'(am[i][pend_addr]) : DW'($urandom);
      b_in[i*DW +: DW] = pend_en ? DW'(bm[pend_addr][i]) : DW'($urandom);
    end
    start = st;
    abort = ab;
    k_len = KW'(kl);
    if (rel) begin
      rst     = 1'b1;
      in_rst  = 1'b0;
      rel_cyc = cyc;
    end
  endtask

  // kind 0: random operands, 1: identity, 2: all 4'h3
  task automatic fill(input int kind, input int k);
    for (int i = 0; i < N; i++) begin
      for (int kk = 0; kk < k; kk++) begin
        case (kind)
          1:       begin sa[i][kk] = (i == kk) ? 1 : 0; sb[kk][i] = (i == kk) ? 1 : 0; end
          2:       begin sa[i][kk] = 3; sb[kk][i] = 3; end
          default: begin sa[i][kk] = int'($urandom_range(0, 15)); sb[kk][i] = int'($urandom_range(0, 15)); end
        endcase
      end
    end
  endtask

  task automatic run_job(input int kind, input int k);
    fill(kind, k);
    tick(1'b1, 1'b0, k);
    repeat ((k == 0) ? 2 : k + 2 * N + 1) tick();
  endtask

  task automatic hit_reset();
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_pe_rst", 32'(pe_rst), 32'd1);
    check_val("rst_rd_en", 32'(a_rd_en), 32'd0);
    check_val("rst_left", 32'(left_bus), 32'd0);
    check_val("rst_up", 32'(up_bus), 32'd0);
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    in_rst   = 1'b1;
    job_v    = 1'b0;
    ever_job = 1'b0;
    pend_en  = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    tick();
    tick(.rel(1'b1));
    tick();
    run_job(1, 4);
    tick(); tick();
    run_job(2, 4);
    tick();
    run_job(0, 0);
    tick(0, 1);
    tick();
    // extra start during FEED must be ignored
    fill(0, 3);
    tick(1, 0, 3);
    tick(); tick();
    tick(1, 0, 9);
    repeat (10) tick();
    // abort in DRAIN, then a clean job
    fill(0, 4);
    tick(1, 0, 4);
    repeat (8) tick();
    tick(0, 1);
    repeat (3) tick();
    run_job(0, 4);
    // start and abort together in IDLE: start wins
    fill(0, 2);
    tick(1, 1, 2);
    repeat (12) tick();
    // async reset mid-FEED, then back-to-back maximum-length jobs
    fill(0, 10);
    tick(1, 0, 10);
    repeat (5) tick();
    hit_reset();
    tick(); tick();
    tick(.rel(1'b1));
    run_job(0, 255);
    run_job(0, 255);
    tick();
    for (int n = 0; n < 14; n++) begin
      int k = int'($urandom_range(0, 12));
      int dur = (k == 0) ? 2 : k + 2 * N + 1;
      int ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, dur)) : -1;
      fill(0, k);
      tick(1, 0, k);
      for (int c = 1; c <= dur + 2; c++) begin
        tick($urandom_range(0, 5) == 0, c == ab_at, int'($urandom_range(0, 15)));
      end
    end
    repeat (40) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
